// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one WIDTH-bit logic unit
// (AND/NAND/OR/XOR) between four requesters, holding each tagged result until acked.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   a,
  input  logic [4*WIDTH-1:0]   b,
  output logic [3:0]           gnt,
  output logic                 out_valid,
  output logic [1:0]           out_id,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ack,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic             win_vld;
  logic [1:0]       idx;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Search ptr, ptr+1, ... (mod 4); first asserted request wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    res = '0;
    case (op_q)
      2'b00: res = a_q & b_q;
      2'b01: res = ~(a_q & b_q);
      2'b10: res = a_q | b_q;
      2'b11: res = a_q ^ b_q;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: if (win_vld) begin
          op_q   <= op[{win, 1'b0} +: 2];
          a_q    <= a[win*WIDTH +: WIDTH];
          b_q    <= b[win*WIDTH +: WIDTH];
          gnt    <= 4'b0001 << win;
          out_id <= win;
        end
        EXEC: begin
          out_data  <= res;
          out_valid <= 1'b1;
          gnt       <= '0;
        end
        RESP: if (out_ack) begin
          out_valid <= 1'b0;
          ptr       <= out_id + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench: transaction-level round-robin/ALU model with directed and random traffic.
module tb_logic_unit_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = '0;
  logic [7:0]       op = '0;
  logic [4*WIDTH-1:0] a = '0, b = '0;
  logic [3:0]       gnt;
  logic             out_valid;
  logic [1:0]       out_id;
  logic [WIDTH-1:0] out_data;
  logic             out_ack = 1'b0;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .out_ack(out_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Global invariants: grant one-hot or zero, never alongside a valid result.
  always @(negedge clk) begin
    check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
    check("gnt_vs_valid", {31'd0, (gnt != 4'd0) && out_valid}, 32'd0);
  end

  function automatic logic [3:0] model_op(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return ~(x & y);
      2'd2:    return x | y;
      default: return x ^ y;
    endcase
  endfunction

  // One transaction, entered at an IDLE negedge with req already driven nonzero.
  task automatic serve(input int d, input bit scr, input logic [3:0] raise,
                       output logic [1:0] gid, output logic [3:0] gdata);
    int w;
    logic [3:0] er;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && req[(mptr + k) % 4]) w = (mptr + k) % 4;
    er = model_op(op[2*w +: 2], a[4*w +: 4], b[4*w +: 4]);
    @(negedge clk);
    check("exec_gnt", {28'd0, gnt}, 32'd1 << w);
    check("exec_valid", {31'd0, out_valid}, 32'd0);
    check("exec_busy", {31'd0, busy}, 32'd1);
    req[w] = 1'b0;
    if (scr) begin
      a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
    end
    out_ack = 1'($urandom);
    @(negedge clk);
    gid = out_id;
    gdata = out_data;
    for (int i = 0; i <= d; i++) begin
      check("resp_valid", {31'd0, out_valid}, 32'd1);
      check("resp_id", {30'd0, out_id}, w);
      check("resp_data", {28'd0, out_data}, {28'd0, er});
      check("resp_gnt", {28'd0, gnt}, 32'd0);
      check("resp_busy", {31'd0, busy}, 32'd1);
      if (i == 0) req = req | raise;
      out_ack = (i == d);
      @(negedge clk);
    end
    out_ack = 1'b0;
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_gnt", {28'd0, gnt}, 32'd0);
    mptr = (w + 1) % 4;
  endtask

  logic [1:0] gid;
  logic [3:0] gdata;

  initial begin
    #1;
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {28'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single AND on requester 0
    req = 4'b0001; op = 8'h00; a = 16'h0008; b = 16'h0009;
    serve(0, 0, 4'd0, gid, gdata);
    check("t1_id", {30'd0, gid}, 32'd0);
    check("t1_data", {28'd0, gdata}, 32'h8);

    // NAND on requester 2
    req = 4'b0100; op = 8'b0001_0000; a = 16'h0D00; b = 16'h0600;
    serve(0, 0, 4'd0, gid, gdata);
    check("t2_id", {30'd0, gid}, 32'd2);
    check("t2_data", {28'd0, gdata}, 32'hB);

    // Fairness: ptr is 3 here, so bring it back to 0 first with requester 3
    req = 4'b1000; serve(0, 0, 4'd0, gid, gdata);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(0, 0, 4'd0, gid, gdata);
      check("rr_order", {30'd0, gid}, i);
    end
    req = 4'b1001;
    serve(0, 0, 4'd0, gid, gdata);
    check("rr_first0", {30'd0, gid}, 32'd0);
    serve(0, 0, 4'd0, gid, gdata);
    check("rr_then3", {30'd0, gid}, 32'd3);

    // Backpressure on requester 1, requester 3 waits
    req = 4'b0010; op = 8'b0000_1100; a = 16'h00A0; b = 16'h0060;
    serve(5, 0, 4'b1000, gid, gdata);
    check("bp_data", {28'd0, gdata}, 32'hC);
    check("bp_req3_pending", {28'd0, req}, 32'h8);
    serve(0, 0, 4'd0, gid, gdata);
    check("bp_next3", {30'd0, gid}, 32'd3);

    // Operand change after grant (ptr is 0)
    req = 4'b0001; op = 8'b0000_0010; a = 16'h0001; b = 16'h0002;
    serve(0, 1, 4'd0, gid, gdata);
    check("opchg_data", {28'd0, gdata}, 32'h3);

    // Reset during RESP
    req = 4'b0100; op = 8'h00; a = 16'h0F00; b = 16'h0F00;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_id", {30'd0, out_id}, 32'd0);
    check("mid_rst_data", {28'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    req = 4'b1000; op = 8'b1100_0000; a = 16'h5000; b = 16'h3000;
    serve(0, 0, 4'd0, gid, gdata);
    check("post_rst_id", {30'd0, gid}, 32'd3);
    check("post_rst_data", {28'd0, gdata}, 32'h6);

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        req = '0;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("idle_noreq_busy", {31'd0, busy}, 32'd0);
        check("idle_noreq_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        req = req | 4'($urandom);
        if (req == 4'd0) req = 4'b0001 << $urandom_range(0, 3);
        serve($urandom_range(0, 4), 1'($urandom), 4'($urandom), gid, gdata);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
